// File: rtl/instr_decode_ctrl.sv
// Instruction decode controller: accepts one instruction, decodes it,
// holds control fields through a stallable EXEC phase, then writes back.
module instr_decode_ctrl #(
  parameter int unsigned EXEC_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [15:0] instr,
  input  logic        stall,
  output logic        instrReady,
  output logic [2:0]  ALUOp,
  output logic        ALUSrcB,
  output logic [11:0] din,
  output logic [1:0]  numBits,
  output logic [1:0]  immShift,
  output logic [3:0]  rsAddr,
  output logic [3:0]  rtAddr,
  output logic [3:0]  rdAddr,
  output logic        regWrite,
  output logic        illegalInstr,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] instr_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        illegal_q;
  logic [15:0] retired_q;
  logic [2:0]  alu_q;
  logic        srcb_q;
  logic [11:0] din_q;
  logic [1:0]  nb_q;
  logic [1:0]  sh_q;
  logic [3:0]  rs_q, rt_q, rd_q;

  logic [3:0]  op;
  logic        dec_legal;
  logic [2:0]  dec_alu;
  logic        dec_srcb;
  logic [1:0]  dec_nb;
  logic [1:0]  dec_sh;
  logic        accept;

  assign op     = instr_q[15:12];
  assign accept = instrValid && ready_q;

  always_comb begin
    dec_legal = 1'b1;
    dec_alu   = 3'b000;
    dec_srcb  = 1'b0;
    dec_nb    = 2'b00;
    dec_sh    = 2'b00;
    unique case (1'b1)
      (op == 4'h1): dec_alu = 3'b000;
      (op == 4'h2): dec_alu = 3'b001;
      (op == 4'h3): dec_alu = 3'b010;
      (op == 4'h4): dec_alu = 3'b011;
      (op == 4'h5): dec_alu = 3'b100;
      (op == 4'h6): dec_srcb = 1'b1;
      (op == 4'h7): begin
        dec_alu  = 3'b101;
        dec_srcb = 1'b1;
        dec_nb   = 2'b01;
        dec_sh   = 2'b10;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = DECODE;
      DECODE:  state_d = dec_legal ? EXEC : IDLE;
      EXEC:    if (!stall && cnt_q == 4'd0) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      alu_q     <= '0;
      srcb_q    <= 1'b0;
      din_q     <= '0;
      nb_q      <= '0;
      sh_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      illegal_q <= 1'b0;
      if (accept) instr_q <= instr;
      if (state_q == DECODE) begin
        cnt_q     <= CNT_LOAD;
        illegal_q <= op[3];
        // NOP and illegal opcodes leave the previous fields in place
        if (dec_legal) begin
          alu_q  <= dec_alu;
          srcb_q <= dec_srcb;
          nb_q   <= dec_nb;
          sh_q   <= dec_sh;
          din_q  <= instr_q[11:0];
          rd_q   <= instr_q[11:8];
          rs_q   <= instr_q[7:4];
          rt_q   <= instr_q[3:0];
        end
      end
      if (state_q == EXEC && !stall && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      if (state_q == WB) retired_q <= retired_q + 16'd1;
    end
  end

  assign instrReady   = ready_q;
  assign ALUOp        = alu_q;
  assign ALUSrcB      = srcb_q;
  assign din          = din_q;
  assign numBits      = nb_q;
  assign immShift     = sh_q;
  assign rsAddr       = rs_q;
  assign rtAddr       = rt_q;
  assign rdAddr       = rd_q;
  assign regWrite     = (state_q == WB);
  assign illegalInstr = illegal_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Bench for instr_decode_ctrl: transaction-level model compared every
// cycle, plus directed vectors with hand-computed expectations.
module tb_instr_decode_ctrl;
  localparam int EC = 3;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        instrValid = 1'b0;
  logic [15:0] instr = '0;
  logic        stall = 1'b0;
  logic        instrReady;
  logic [2:0]  ALUOp;
  logic        ALUSrcB;
  logic [11:0] din;
  logic [1:0]  numBits;
  logic [1:0]  immShift;
  logic [3:0]  rsAddr, rtAddr, rdAddr;
  logic        regWrite;
  logic        illegalInstr;
  logic [15:0] retired;

  instr_decode_ctrl #(.EXEC_CYCLES(EC)) dut (
    .CLK(CLK), .reset(reset), .instrValid(instrValid),
    .instr(instr), .stall(stall), .instrReady(instrReady),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .din(din),
    .numBits(numBits), .immShift(immShift),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .rdAddr(rdAddr),
    .regWrite(regWrite), .illegalInstr(illegalInstr),
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;
  int acc = 0;
  bit run_cmp = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: an instruction occupies one decode cycle, EC unstalled
  // execute cycles and one write-back cycle; ready only when none pending.
  bit          m_ready, m_dec, m_wb, m_ill;
  int          m_exec;
  logic [15:0] m_lat, m_ret;
  logic [2:0]  m_alu;
  logic        m_srcb;
  logic [1:0]  m_nb, m_sh;
  logic [11:0] m_din;
  logic [3:0]  m_rd, m_rs, m_rt;

  always @(posedge CLK or negedge reset) begin : model
    int o;
    if (!reset) begin
      m_ready = 0; m_dec = 0; m_wb = 0; m_ill = 0; m_exec = 0;
      m_lat = 0; m_ret = 0; m_alu = 0; m_srcb = 0; m_nb = 0;
      m_sh = 0; m_din = 0; m_rd = 0; m_rs = 0; m_rt = 0;
    end else begin
      m_ill = 0;
      if (m_wb) begin
        m_ret = m_ret + 16'd1;
        m_wb = 0;
      end else if (m_dec) begin
        m_dec = 0;
        o = int'(m_lat[15:12]);
        if (o >= 1 && o <= 7) begin
          m_alu  = (o == 6) ? 3'd0 : (o == 7) ? 3'd5 : 3'(o - 1);
          m_srcb = (o >= 6);
          m_nb   = (o == 7) ? 2'b01 : 2'b00;
          m_sh   = (o == 7) ? 2'b10 : 2'b00;
          m_din  = m_lat[11:0];
          m_rd   = m_lat[11:8];
          m_rs   = m_lat[7:4];
          m_rt   = m_lat[3:0];
          m_exec = EC;
        end else if (o >= 8) begin
          m_ill = 1;
        end
      end else if (m_exec > 0) begin
        if (!stall) begin
          m_exec--;
          if (m_exec == 0) m_wb = 1;
        end
      end else if (m_ready && instrValid) begin
        m_dec = 1;
        m_lat = instr;
      end
      m_ready = !(m_dec || m_exec > 0 || m_wb);
    end
  end

  always @(negedge CLK) begin
    if (run_cmp) begin
      chk("instrReady", instrReady, m_ready);
      chk("ALUOp", ALUOp, m_alu);
      chk("ALUSrcB", ALUSrcB, m_srcb);
      chk("din", din, m_din);
      chk("numBits", numBits, m_nb);
      chk("immShift", immShift, m_sh);
      chk("rsAddr", rsAddr, m_rs);
      chk("rtAddr", rtAddr, m_rt);
      chk("rdAddr", rdAddr, m_rd);
      chk("regWrite", regWrite, m_wb);
      chk("illegalInstr", illegalInstr, m_ill);
      chk("retired", retired, m_ret);
    end
  end

  task automatic issue(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge CLK);
    while (!instrReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      vecs++;
      miss++;
      $display("FAIL accept_timeout: instrReady=%b expected 1", instrReady);
    end
    instrValid = 1'b1;
    instr = w;
    @(posedge CLK);
    #1 acc = cyc;
    @(negedge CLK);
    instrValid = 1'b0;
  endtask

  task automatic wait_rw(output int lat);
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      if (regWrite) begin
        lat = cyc - acc + 1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic watch(output int ill, output int rw, output logic rdy0);
    ill = 0;
    rw = 0;
    rdy0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 0) rdy0 = instrReady;
      if (illegalInstr) ill++;
      if (regWrite) rw++;
    end
  endtask

  initial begin
    int lat, ill, rw;
    logic rdy0;
    #12;
    chk("rst_ready", instrReady, 0);
    chk("rst_retired", retired, 0);
    chk("rst_regWrite", regWrite, 0);
    chk("rst_rdAddr", rdAddr, 0);
    run_cmp = 1;
    @(negedge CLK);
    #2 reset = 1'b1;
    @(posedge CLK);
    #1 chk("ready_first_edge", instrReady, 1);

    issue(16'h1123);
    wait_rw(lat);
    chk("add_latency", 16'(lat), 5);
    chk("add_ALUOp", ALUOp, 3'b000);
    chk("add_srcb", ALUSrcB, 0);
    chk("add_rs", rsAddr, 2);
    chk("add_rt", rtAddr, 3);
    chk("add_rd", rdAddr, 1);
    @(posedge CLK);
    #1 chk("add_retired", retired, 1);

    issue(16'h75AB);
    wait_rw(lat);
    chk("lui_latency", 16'(lat), 5);
    chk("lui_ALUOp", ALUOp, 3'b101);
    chk("lui_srcb", ALUSrcB, 1);
    chk("lui_numBits", numBits, 2'b01);
    chk("lui_immShift", immShift, 2'b10);
    chk("lui_din", din, 12'h5AB);

    issue(16'h6304);
    @(negedge CLK);
    stall = 1'b1;
    repeat (4) @(negedge CLK);
    stall = 1'b0;
    wait_rw(lat);
    chk("addi_stall_latency", 16'(lat), 9);
    chk("addi_srcb", ALUSrcB, 1);
    chk("addi_din", din, 12'h304);
    chk("addi_rd", rdAddr, 3);

    issue(16'hA000);
    watch(ill, rw, rdy0);
    chk("illegal_pulses", 16'(ill), 1);
    chk("illegal_regWrite", 16'(rw), 0);
    chk("illegal_idle", rdy0, 1);

    issue(16'h0FFF);
    watch(ill, rw, rdy0);
    chk("nop_pulses", 16'(ill), 0);
    chk("nop_regWrite", 16'(rw), 0);
    chk("nop_retired", retired, 3);

    issue(16'h1123);
    @(negedge CLK);
    @(negedge CLK);
    #2 reset = 1'b0;
    #1;
    chk("abort_ready", instrReady, 0);
    chk("abort_regWrite", regWrite, 0);
    chk("abort_retired", retired, 0);
    chk("abort_rs", rsAddr, 0);
    chk("abort_din", din, 0);
    repeat (2) @(negedge CLK);
    #2 reset = 1'b1;
    @(posedge CLK);
    #1 chk("abort_ready_after", instrReady, 1);
    chk("abort_no_rw", regWrite, 0);

    @(negedge CLK);
    #2 force dut.retired_q = 16'hFFFF;
    m_ret = 16'hFFFF;
    #1 release dut.retired_q;
    issue(16'h1123);
    wait_rw(lat);
    chk("wrap_latency", 16'(lat), 5);
    @(posedge CLK);
    #1 chk("wrap_retired", retired, 16'h0000);

    repeat (2) @(negedge CLK);
    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
